// File: rtl/alu_pkg.sv
// Shared ALU control encodings: ALUcontrol codes, main-control ALUOp codes,
// and the funct/opcode values the ALU control decoder recognises.
package alu_pkg;

  // 3-bit ALUcontrol codes, also used by the EX-stage ALU
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  // Main-control ALUOp
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // R-type funct field
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // I-type opcodes
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       undecodable;
  } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Op-in / ALUcontrol-out handshake bundle for alu_ctrl_stage.
// slave = the stage itself, master = the ID/EX environment around it.
interface alu_ctrl_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_control;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  modport slave (
    input  in_valid, alu_op, opcode, funct, in_tag, flush, out_ready,
    output in_ready, out_valid, alu_control, out_tag, illegal
  );

  modport master (
    output in_valid, alu_op, opcode, funct, in_tag, flush, out_ready,
    input  in_ready, out_valid, alu_control, out_tag, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU control decoder: {ALUOp, opcode, funct} ->
// {alu_control, undecodable}. Undecodable encodings fall back to add.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_dec_t   dec
);

  always_comb begin
    dec.ctrl        = ALU_ADD;
    dec.undecodable = 1'b0;
    case (alu_op)
      ALUOP_MEM:    dec.ctrl = ALU_ADD;
      ALUOP_BRANCH: dec.ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: dec.ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: dec.ctrl = ALU_SUB;
          FN_AND:          dec.ctrl = ALU_AND;
          FN_OR:           dec.ctrl = ALU_OR;
          FN_XOR:          dec.ctrl = ALU_XOR;
          FN_NOR:          dec.ctrl = ALU_NOR;
          FN_SLT:          dec.ctrl = ALU_SLT;
          FN_SLTU:         dec.ctrl = ALU_SLTU;
          default:         dec.undecodable = 1'b1;
        endcase
      end
      default: begin
        case (opcode)
          OP_ADDI, OP_ADDIU: dec.ctrl = ALU_ADD;
          OP_ANDI:           dec.ctrl = ALU_AND;
          OP_ORI:            dec.ctrl = ALU_OR;
          OP_XORI:           dec.ctrl = ALU_XOR;
          OP_SLTI:           dec.ctrl = ALU_SLT;
          OP_SLTIU:          dec.ctrl = ALU_SLTU;
          default:           dec.undecodable = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decode, then a 2-entry skid buffer (output reg + skid reg)
// toward EX. Optional ALU_CTRL_ILLEGAL_EN carries an undecodable flag per op.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  alu_ctrl_stage_if.slave bus
);

  alu_dec_t dec;

  alu_ctrl_decode u_decode (
    .alu_op (bus.alu_op),
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .dec    (dec)
  );

  logic             out_valid_reg;
  logic [2:0]       out_ctrl_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             skid_valid_reg;
  logic [2:0]       skid_ctrl_reg;
  logic [TAG_W-1:0] skid_tag_reg;

  logic accept;
  logic hold;
  logic load_out_new;
  logic load_skid;

  // in_ready depends only on registered state, never on out_ready
  assign accept       = bus.in_valid & ~skid_valid_reg;
  assign hold         = out_valid_reg & ~bus.out_ready;
  assign load_out_new = accept & ~hold & ~skid_valid_reg;
  assign load_skid    = accept & (hold | skid_valid_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (hold) begin
      if (accept)
        skid_valid_reg <= 1'b1;
    end else if (skid_valid_reg) begin
      out_valid_reg  <= 1'b1;
      skid_valid_reg <= accept;
    end else begin
      out_valid_reg  <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctrl_reg  <= ALU_ADD;
      out_tag_reg   <= '0;
      skid_ctrl_reg <= ALU_ADD;
      skid_tag_reg  <= '0;
    end else begin
      if (!hold && skid_valid_reg) begin
        out_ctrl_reg <= skid_ctrl_reg;
        out_tag_reg  <= skid_tag_reg;
      end else if (load_out_new) begin
        out_ctrl_reg <= dec.ctrl;
        out_tag_reg  <= bus.in_tag;
      end
      if (load_skid) begin
        skid_ctrl_reg <= dec.ctrl;
        skid_tag_reg  <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready    = ~skid_valid_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.alu_control = out_ctrl_reg;
  assign bus.out_tag     = out_tag_reg;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic out_ill_reg;
  logic skid_ill_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ill_reg  <= 1'b0;
      skid_ill_reg <= 1'b0;
    end else begin
      if (!hold && skid_valid_reg)
        out_ill_reg <= skid_ill_reg;
      else if (load_out_new)
        out_ill_reg <= dec.undecodable;
      if (load_skid)
        skid_ill_reg <= dec.undecodable;
    end
  end

  assign bus.illegal = out_valid_reg & out_ill_reg;
`else
  logic unused_undecodable;
  assign unused_undecodable = dec.undecodable;
  assign bus.illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed plan items with literal
// expectations plus randomized traffic against a FIFO-level reference model.
module tb_alu_ctrl_stage;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_stage_if #(.TAG_W(TAG_W)) bus ();

  alu_ctrl_stage #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // Reference model: decode tables and an ordered queue of at most 2 ops
  typedef struct {
    int ctrl;
    int tag;
    bit ill;
  } ent_t;

  int   fmap [64];
  int   omap [64];
  ent_t q [$];

  function automatic ent_t model_dec(input int op, input int oc, input int fn, input int tg);
    ent_t e;
    int   code;
    e.tag = tg;
    e.ill = 1'b0;
    code  = (op == 0) ? 0 : (op == 1) ? 1 : (op == 2) ? fmap[fn] : omap[oc];
    if (code < 0) begin
      e.ctrl = 0;
      e.ill  = ILL_EN;
    end else begin
      e.ctrl = code;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = bus.in_valid && (q.size() < 2);
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && bus.out_ready)
        void'(q.pop_front());
      if (acc)
        q.push_back(model_dec(int'(bus.alu_op), int'(bus.opcode), int'(bus.funct), int'(bus.in_tag)));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end else begin
      $display("ok   %s t=%0t value=%0d", name, $time, act);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2)) begin
        n_errors++;
        $display("FAIL cmp_hs t=%0t actual=v%0b/r%0b required=v%0b/r%0b",
                 $time, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (int'(bus.alu_control) != q[0].ctrl || int'(bus.out_tag) != q[0].tag ||
            bus.illegal !== q[0].ill) begin
          n_errors++;
          $display("FAIL cmp_data t=%0t actual=c%0d/t%0d/i%0b required=c%0d/t%0d/i%0b",
                   $time, bus.alu_control, bus.out_tag, bus.illegal,
                   q[0].ctrl, q[0].tag, q[0].ill);
        end
      end else begin
        n_checks++;
        if (bus.illegal !== 1'b0) begin
          n_errors++;
          $display("FAIL cmp_ill_idle t=%0t actual=%0b required=0", $time, bus.illegal);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input bit v, input logic [1:0] op, input logic [5:0] oc,
                      input logic [5:0] fn, input logic [TAG_W-1:0] tg);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.opcode   = oc;
    bus.funct    = fn;
    bus.in_tag   = tg;
  endtask

  // {alu_op, opcode, funct, expected alu_control}
  logic [16:0] tbl [19];

  initial begin
    for (int i = 0; i < 64; i++) begin
      fmap[i] = -1;
      omap[i] = -1;
    end
    fmap[32] = 0; fmap[33] = 0; fmap[34] = 1; fmap[35] = 1;
    fmap[36] = 2; fmap[37] = 3; fmap[38] = 4; fmap[39] = 5;
    fmap[42] = 6; fmap[43] = 7;
    omap[8]  = 0; omap[9]  = 0; omap[12] = 2; omap[13] = 3;
    omap[14] = 4; omap[10] = 6; omap[11] = 7;

    tbl = '{
      {2'b00, 6'b100011, 6'b000000, 3'd0}, {2'b01, 6'b000100, 6'b111111, 3'd1},
      {2'b10, 6'b000000, 6'b100000, 3'd0}, {2'b10, 6'b000000, 6'b100001, 3'd0},
      {2'b10, 6'b000000, 6'b100010, 3'd1}, {2'b10, 6'b000000, 6'b100011, 3'd1},
      {2'b10, 6'b000000, 6'b100100, 3'd2}, {2'b10, 6'b000000, 6'b100101, 3'd3},
      {2'b10, 6'b000000, 6'b100110, 3'd4}, {2'b10, 6'b000000, 6'b100111, 3'd5},
      {2'b10, 6'b000000, 6'b101010, 3'd6}, {2'b10, 6'b000000, 6'b101011, 3'd7},
      {2'b11, 6'b001000, 6'b000000, 3'd0}, {2'b11, 6'b001001, 6'b000000, 3'd0},
      {2'b11, 6'b001100, 6'b000000, 3'd2}, {2'b11, 6'b001101, 6'b000000, 3'd3},
      {2'b11, 6'b001110, 6'b000000, 3'd4}, {2'b11, 6'b001010, 6'b000000, 3'd6},
      {2'b11, 6'b001011, 6'b000000, 3'd7}
    };

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();
    tick();
    cmp_en = 1'b1;

    // Reset state
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_alu_control", int'(bus.alu_control), 0);
    chk("rst_out_tag", int'(bus.out_tag), 0);
    chk("rst_illegal", int'(bus.illegal), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // First op: slt, tag 7, one cycle latency
    rst = 1'b0;
    send(1'b1, 2'b10, 6'd0, 6'b101010, 5'd7);
    tick();
    chk("first_valid", int'(bus.out_valid), 1);
    chk("first_ctrl", int'(bus.alu_control), 6);
    chk("first_tag", int'(bus.out_tag), 7);

    // Whole decode table back to back
    for (int i = 0; i < 19; i++) begin
      logic [16:0] e;
      e = tbl[i];
      send(1'b1, e[16:15], e[14:9], e[8:3], TAG_W'(i + 8));
      tick();
      chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), 1);
      chk($sformatf("tbl%0d_ctrl", i), int'(bus.alu_control), int'(e[2:0]));
      chk($sformatf("tbl%0d_tag", i), int'(bus.out_tag), i + 8);
    end
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();

    // Stall with A, B; release delivers A then B
    bus.out_ready = 1'b0;
    send(1'b1, 2'b00, 6'd0, 6'd0, 5'd1);
    tick();
    chk("stall_a_tag", int'(bus.out_tag), 1);
    chk("stall_a_rdy", int'(bus.in_ready), 1);
    send(1'b1, 2'b01, 6'd0, 6'd0, 5'd2);
    tick();
    chk("stall_b_rdy", int'(bus.in_ready), 0);
    chk("stall_hold_tag", int'(bus.out_tag), 1);
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();
    chk("stall_hold2_tag", int'(bus.out_tag), 1);
    chk("stall_hold2_ctrl", int'(bus.alu_control), 0);
    bus.out_ready = 1'b1;
    tick();
    chk("release_b_tag", int'(bus.out_tag), 2);
    chk("release_b_ctrl", int'(bus.alu_control), 1);
    chk("release_rdy", int'(bus.in_ready), 1);
    tick();
    chk("release_empty", int'(bus.out_valid), 0);

    // Flush with both entries full plus a concurrent in_valid
    bus.out_ready = 1'b0;
    send(1'b1, 2'b00, 6'd0, 6'd0, 5'd3);
    tick();
    send(1'b1, 2'b01, 6'd0, 6'd0, 5'd4);
    tick();
    send(1'b1, 2'b11, 6'b001101, 6'd0, 5'd5);
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", int'(bus.out_valid), 0);
    chk("flush_rdy", int'(bus.in_ready), 1);
    bus.flush = 1'b0;
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("flush_none", int'(bus.out_valid), 0);

    // Flush discards an op accepted on the same edge
    bus.out_ready = 1'b0;
    send(1'b1, 2'b00, 6'd0, 6'd0, 5'd6);
    tick();
    send(1'b1, 2'b01, 6'd0, 6'd0, 5'd11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("flush_acc_none", int'(bus.out_valid), 0);

    // Undecodable R-type funct
    send(1'b1, 2'b10, 6'd0, 6'b001000, 5'd12);
    tick();
    chk("undec_ctrl", int'(bus.alu_control), 0);
    chk("undec_ill", int'(bus.illegal), int'(ILL_EN));
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();

    // Reset while stalled with two ops
    bus.out_ready = 1'b0;
    send(1'b1, 2'b01, 6'd0, 6'd0, 5'd9);
    tick();
    send(1'b1, 2'b10, 6'd0, 6'b101011, 5'd10);
    tick();
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    rst = 1'b1;
    tick();
    chk("rst_stall_valid", int'(bus.out_valid), 0);
    chk("rst_stall_ctrl", int'(bus.alu_control), 0);
    chk("rst_stall_tag", int'(bus.out_tag), 0);
    chk("rst_stall_rdy", int'(bus.in_ready), 1);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] op;
      logic [5:0] oc;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      oc = ($urandom_range(0, 3) != 0) ? 6'(8 + $urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 3) != 0) ? 6'(32 + $urandom_range(0, 15)) : 6'($urandom_range(0, 63));
      send(1'($urandom_range(0, 3) != 0), op, oc, fn, TAG_W'($urandom_range(0, 31)));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst       = 1'b0;
    bus.flush = 1'b0;
    send(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Producer end of the 3-bit ALUcontrol interface. Decodes main-control ALUOp plus instruction opcode/funct into the ALUcontrol code the EX-stage ALU consumes.
- Registers the result, with a sideband tag, through a 2-entry skid buffer that uses a valid/ready handshake.
- Sits between the ID-stage main control and the EX-stage ALU. Supports stall (backpressure) and flush.

Parameters:
- TAG_W, 5, width of the sideband tag (destination register number) carried with each op.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream op present
- in_ready  out  1  stage can accept an op this cycle
- alu_op  in  2  main-control ALUOp: 00 mem/addi, 01 branch, 10 R-type, 11 I-type logic/compare
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- in_tag  in  TAG_W  sideband tag
- flush  in  1  discard all buffered ops
- out_valid  out  1  ALUcontrol/out_tag valid toward EX
- out_ready  in  1  EX accepts this cycle
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu
- out_tag  out  TAG_W  tag of presented op
- illegal  out  1  presented op had an undecodable funct/opcode (feature-gated, see below)

Behaviour:
- Reset (rst=1 at edge): out_valid=0, alu_control=000, out_tag=0, illegal=0, skid empty, in_ready=1 after the edge. Reset overrides flush and all handshakes.
- Decode is combinational on the inputs; its result is captured on accept (in_valid & in_ready).
- Decode rules:
  - alu_op 00 -> add.
  - alu_op 01 -> sub.
  - alu_op 10 by funct:
    - 100000/100001 -> add; 100010/100011 -> sub.
    - 100100 -> and; 100101 -> or; 100110 -> xor; 100111 -> nor.
    - 101010 -> slt; 101011 -> sltu.
    - any other funct -> add, undecodable.
  - alu_op 11 by opcode:
    - 001000/001001 -> add.
    - 001100 -> and; 001101 -> or; 001110 -> xor.
    - 001010 -> slt; 001011 -> sltu.
    - any other opcode -> add, undecodable.
- Latency: 1 cycle. An op accepted at edge N is presented with out_valid=1 after edge N, provided no older op is pending.
- Output register:
  - Transfer occurs when out_valid & out_ready.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Skid register:
  - in_ready = ~skid_valid, registered, with no combinational path from out_ready.
  - On accept while the output register is held (out_valid & ~out_ready), the op goes to the skid.
  - When the output drains, skid content moves to the output register on that same edge. A new accept that same edge goes to the skid.
- Simultaneous accept and drain with skid empty: the new op loads the output register directly, so back-to-back throughput is 1 op/cycle.
- Ordering is strictly FIFO.
- Flush: at the edge, out_valid=0 and skid cleared. An op accepted in the same cycle is also discarded. in_ready=1 next cycle.
- Reset mid-stall: all buffered ops are lost and no transfer is reported.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_EN.
- Defined:
  - The illegal bit is stored with each op (both entries).
  - `illegal` is asserted with out_valid for undecodable ops; alu_control is still 000.
- Undefined:
  - The illegal output is tied 0 and no storage is generated.
  - Undecodable ops silently map to add.

Decomposition:
- Shared package alu_pkg:
  - The 3-bit ALUcontrol localparams ALU_ADD..ALU_SLTU, also to be adopted by the ALU.
  - ALUOp codes.
  - funct and opcode constants.
- One natural sub-module: alu_ctrl_decode, the pure combinational decoder producing {alu_control, undecodable}. The stage instantiates it ahead of the skid buffer.

Test Plan:
- Reset then alu_op=10, funct=101010, tag=7, out_ready=1 -> next cycle out_valid=1, alu_control=110, out_tag=7.
- All table entries sequentially, out_ready=1 -> 1 op/cycle, codes match table (e.g. opcode 001110 with alu_op=11 -> 100).
- out_ready=0 for 3 cycles while sending ops A(tag 1), B(tag 2):
  - in_ready drops after B.
  - Outputs hold A.
  - Releasing out_ready delivers A then B in consecutive cycles, and in_ready returns to 1.
- Flush with both entries full plus concurrent in_valid -> next cycle out_valid=0, in_ready=1, none of the three ops ever appear.
- alu_op=10, funct=001000 -> alu_control=000. With ALU_CTRL_ILLEGAL_EN, illegal=1; without it, illegal=0.
- rst asserted while stalled with 2 ops -> out_valid=0, alu_control=000, in_ready=1 after the edge.
